// File: rtl/serial_sub4bit_pkg.sv
// Shared state encoding and default width for the bit-serial subtractor.
// The optional overflow flag is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub4bit_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub4bit_full_adder.sv
// Single-bit full adder cell; the serial subtractor reuses it once per bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub4bit.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag.
module serial_sub4bit
    import serial_sub4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             fa_s, fa_cout;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Subtraction as A + ~B + ~Bin through the one shared adder cell
    full_adder u_fa (
        .a    (a_q[cnt_q]),
        .b    (~b_q[cnt_q]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    carry_d = ~Bin;
                    a_d     = A;
                    b_d     = B;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                carry_d = fa_cout;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                    diff_d  = {fa_s, sum_q[WIDTH-1:1]};
                    bout_d  = ~fa_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow is the carry into the MSB differing from the carry out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == SHIFT && last_bit) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: doc/serial_sub4bit.md
SERIAL_SUB4BIT -- requirements
Module: serial_sub4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 A  input  WIDTH  minuend, captured on the accepted start edge.
REQ-006 B  input  WIDTH  subtrahend, captured on the accepted start edge.
REQ-007 Bin  input  1  borrow-in, captured on the accepted start edge.
REQ-008 Diff  output  WIDTH  registered difference.
REQ-009 Bout  output  1  registered borrow-out.
REQ-010 Ovf  output  1  registered signed-overflow flag (see Configuration).
REQ-011 busy  output  1  high while bits are being processed.
REQ-012 done  output  1  one-cycle pulse when Diff/Bout/Ovf become valid.

Function
REQ-013 The block SHALL compute Diff = (A - B - Bin) mod 2^WIDTH and Bout = 1 iff A < B + Bin (unsigned).
REQ-014 The block SHALL process one bit per clock, LSB first, through a single full-adder cell fed with A[i], ~B[i] and the running carry; the initial carry is ~Bin, and Bout is ~carry after the MSB.
REQ-015 States: IDLE (busy=0), SHIFT (busy=1, bit counter 0..WIDTH-1), DONE (busy=0, done=1 for exactly one cycle).
REQ-016 Transitions: IDLE->SHIFT on start=1; SHIFT->SHIFT while counter<WIDTH-1; SHIFT->DONE when counter=WIDTH-1; DONE->SHIFT on start=1, else DONE->IDLE.
REQ-017 Latency: for start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, and busy SHALL be high from edge k+1 through edge k+WIDTH.
REQ-018 start while busy=1 SHALL be ignored; A/B/Bin changes while busy=1 SHALL NOT affect the result.
REQ-019 Diff/Bout/Ovf SHALL update only on the edge that enters DONE and SHALL hold until the next DONE entry.
REQ-020 A start accepted in the DONE cycle SHALL begin a new operation with no idle cycle.

Reset
REQ-021 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear Diff, Bout, Ovf, busy, done, the bit counter and the carry to 0.
REQ-022 Reset asserted mid-SHIFT SHALL abort the operation: no done pulse, and the previous result is discarded (outputs = 0).
REQ-023 Reset SHALL take priority over start on the same edge.

Configuration
REQ-024 Macro SERIAL_SUB_OVF_EN defined: Ovf = 1 iff A[MSB] != B[MSB] and Diff[MSB] != A[MSB] (two's-complement overflow, including the Bin contribution via the final carry-in/carry-out XOR).
REQ-025 Macro SERIAL_SUB_OVF_EN undefined: the Ovf port SHALL remain and be tied to 0, and no overflow logic is synthesised.

Structure
REQ-026 The shared package SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 The 1-bit cell SHALL be a separate sub-module, full_adder (a, b, cin -> s, cout), instantiated exactly once.

Verification
REQ-028 Reset, then start with A=4'h3, B=4'h2, Bin=0 -> done 4 cycles after the accepting edge; Diff=4'h1, Bout=0, Ovf=0.
REQ-029 A=4'h1, B=4'h2, Bin=0 -> Diff=4'hF, Bout=1; A=4'h0, B=4'h0, Bin=1 -> Diff=4'hF, Bout=1.
REQ-030 With SERIAL_SUB_OVF_EN defined, A=4'h8, B=4'h1, Bin=0 -> Diff=4'h7, Ovf=1; undefined -> Ovf=0.
REQ-031 Pulse start again at busy cycle 2 with different operands -> ignored; result matches the first operands, and exactly one done pulse occurs.
REQ-032 Assert rst_n=0 for one edge at busy cycle 2 -> busy=0 and done never pulses; a subsequent start with A=4'h8, B=4'h8, Bin=1 -> Diff=4'hF, Bout=1.
REQ-033 Back-to-back: start held high through the DONE cycle -> second operation busy on the next edge; done pulses exactly WIDTH+1 cycles apart.
